trap_sequencer: RTL and testbench

Trap-entry controller for the execute stage. It arbitrates synchronous exceptions against timer, software and external interrupts, then drains the pipeline stall and drives the one-cycle trap commit into the CSR file (`trap_active`/`cause`/`mepc`/`tval`). Finally it issues a single-cycle fetch redirect to the handler address. It sits between the EX-stage exception/interrupt sources and `cs_reg_file`/fetch.

---
 rtl/trap_sequencer.sv | 138 +++++++++++++
 tb/tb_trap_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap-entry controller: arbitrates EX exceptions against interrupts, drains the stall, commits the trap to the CSRs, then redirects fetch.
// Optional CERES_TRAP_VECTORED_EN: vectored handler addressing for interrupts when mtvec mode is 01.
module trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            timer_irq_i,
  input  logic            sw_irq_i,
  input  logic            ext_irq_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  output logic            trap_active_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic [XLEN-1:0] trap_mepc_o,
  output logic [XLEN-1:0] trap_tval_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

  localparam logic [XLEN-1:0] CAUSE_SW  = {1'b1, (XLEN-1)'(3)};
  localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, (XLEN-1)'(7)};
  localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, (XLEN-1)'(11)};

  state_t          state_q, state_d;
  logic            take;
  logic            take_irq;
  logic [XLEN-1:0] cause_d;
  logic [XLEN-1:0] tval_d;
  logic            irq_gate;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] handler_pc;

  // Interrupts only at a valid instruction boundary; exceptions need a valid EX instruction.
  assign irq_gate = mstatus_mie_i & ex_valid_i;

  always_comb begin
    take     = 1'b0;
    take_irq = 1'b0;
    cause_d  = '0;
    tval_d   = '0;
    if (ex_valid_i && exc_valid_i) begin
      take    = 1'b1;
      cause_d = exc_cause_i;
      tval_d  = exc_tval_i;
    end else if (irq_gate && ext_irq_i && mie_i[11]) begin
      take     = 1'b1;
      take_irq = 1'b1;
      cause_d  = CAUSE_EXT;
    end else if (irq_gate && sw_irq_i && mie_i[3]) begin
      take     = 1'b1;
      take_irq = 1'b1;
      cause_d  = CAUSE_SW;
    end else if (irq_gate && timer_irq_i && mie_i[7]) begin
      take     = 1'b1;
      take_irq = 1'b1;
      cause_d  = CAUSE_TMR;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (take) state_d = DRAIN;
      DRAIN:    if (!stall_i) state_d = COMMIT;
      COMMIT:   state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload is captured only on the IDLE->DRAIN edge and held until the next trap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trap_cause_o <= '0;
      trap_mepc_o  <= '0;
      trap_tval_o  <= '0;
    end else if (state_q == IDLE && take) begin
      trap_cause_o <= cause_d;
      trap_mepc_o  <= ex_pc_i;
      trap_tval_o  <= tval_d;
    end
  end

  assign base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef CERES_TRAP_VECTORED_EN
  logic trap_irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trap_irq_q <= 1'b0;
    end else if (state_q == IDLE && take) begin
      trap_irq_q <= take_irq;
    end
  end

  always_comb begin
    handler_pc = base;
    if (trap_irq_q && mtvec_i[1:0] == 2'b01) begin
      handler_pc = base + {trap_cause_o[XLEN-3:0], 2'b00};
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^{mtvec_i[1:0], take_irq};
  assign handler_pc  = base;
`endif

  logic unused_mie;
  assign unused_mie = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  assign trap_active_o = (state_q == COMMIT);
  assign redirect_o    = (state_q == REDIRECT);
  assign redirect_pc_o = redirect_o ? handler_pc : '0;
  assign flush_o       = (state_q != IDLE);
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: expected traps are queued when stimulus is driven and checked when the DUT commits.
// Honours CERES_TRAP_VECTORED_EN for the expected handler address.
module tb_trap_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        stall_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [31:0] ex_pc_i = '0;
  logic        exc_valid_i = 1'b0;
  logic [31:0] exc_cause_i = '0;
  logic [31:0] exc_tval_i = '0;
  logic        timer_irq_i = 1'b0;
  logic        sw_irq_i = 1'b0;
  logic        ext_irq_i = 1'b0;
  logic        mstatus_mie_i = 1'b0;
  logic [31:0] mie_i = '0;
  logic [31:0] mtvec_i = '0;
  logic        trap_active_o;
  logic [31:0] trap_cause_o, trap_mepc_o, trap_tval_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  trap_sequencer #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i),
    .timer_irq_i(timer_irq_i), .sw_irq_i(sw_irq_i), .ext_irq_i(ext_irq_i),
    .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i), .mtvec_i(mtvec_i),
    .trap_active_o(trap_active_o), .trap_cause_o(trap_cause_o),
    .trap_mepc_o(trap_mepc_o), .trap_tval_o(trap_tval_o),
    .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] mepc;
    logic [31:0] tval;
    logic [31:0] rpc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] handler(input logic [31:0] mtvec, input logic [31:0] cause,
                                          input bit is_irq);
    logic [31:0] b;
    b = {mtvec[31:2], 2'b00};
`ifdef CERES_TRAP_VECTORED_EN
    if (is_irq && mtvec[1:0] == 2'b01) b = b + (cause << 2);
`else
    if (is_irq) b = b;
`endif
    return b;
  endfunction

  task automatic push_exp(input logic [31:0] cause, input logic [31:0] mepc,
                          input logic [31:0] tval, input bit is_irq, input int lat);
    exp_t e;
    e.cause = cause;
    e.mepc  = mepc;
    e.tval  = tval;
    e.rpc   = handler(mtvec_i, cause, is_irq);
    e.lat   = lat;
    sb.push_back(e);
  endtask

  // Called right after an event is driven (before the capturing edge).
  task automatic check_trap(input int stall_cycles, input bit hold_irq);
    exp_t e;
    int   k;
    bit   seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk_i);
      k++;
      if (k == 1) begin
        exc_valid_i = 1'b0;
        if (!hold_irq) begin
          timer_irq_i = 1'b0;
          sw_irq_i    = 1'b0;
          ext_irq_i   = 1'b0;
        end
      end
      stall_i = (k <= stall_cycles);
      if (trap_active_o) seen = 1'b1;
      else chk("flush_in_drain", {31'd0, flush_o}, 32'd1);
    end
    chk("trap_seen", {31'd0, seen}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("trap_latency", k, e.lat);
      chk("trap_cause", trap_cause_o, e.cause);
      chk("trap_mepc", trap_mepc_o, e.mepc);
      chk("trap_tval", trap_tval_o, e.tval);
      chk("flush_commit", {31'd0, flush_o}, 32'd1);
      @(negedge clk_i);
      chk("redirect_strobe", {31'd0, redirect_o}, 32'd1);
      chk("trap_active_once", {31'd0, trap_active_o}, 32'd0);
      chk("redirect_pc", redirect_pc_o, e.rpc);
      chk("flush_redirect", {31'd0, flush_o}, 32'd1);
      @(negedge clk_i);
      chk("idle_after", {31'd0, busy_o}, 32'd0);
      chk("redirect_once", {31'd0, redirect_o}, 32'd0);
    end
  endtask

  initial begin
    mtvec_i       = 32'h8000_1000;
    mie_i         = 32'h0000_0888;
    mstatus_mie_i = 1'b1;
    ex_valid_i    = 1'b1;
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_trap_active", {31'd0, trap_active_o}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
    chk("rst_cause", trap_cause_o, 32'd0);
    chk("rst_mepc", trap_mepc_o, 32'd0);
    chk("rst_tval", trap_tval_o, 32'd0);
    chk("rst_redirect_pc", redirect_pc_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Plain exception, no stall
    ex_pc_i = 32'h8000_0100; exc_cause_i = 32'd2; exc_tval_i = 32'h0000_0013; exc_valid_i = 1'b1;
    push_exp(32'd2, 32'h8000_0100, 32'h0000_0013, 1'b0, 2);
    check_trap(0, 1'b0);
    @(negedge clk_i);
    chk("payload_stable", trap_cause_o, 32'd2);

    // Exception and timer together: exception first, timer re-arbitrated in IDLE
    ex_pc_i = 32'h8000_0200; exc_cause_i = 32'd2; exc_tval_i = 32'h0000_0044;
    exc_valid_i = 1'b1; timer_irq_i = 1'b1;
    push_exp(32'd2, 32'h8000_0200, 32'h0000_0044, 1'b0, 2);
    push_exp(32'h8000_0007, 32'h8000_0200, 32'd0, 1'b1, 2);
    check_trap(0, 1'b1);
    check_trap(0, 1'b0);
    @(negedge clk_i);

    // Interrupt priority
    ex_pc_i = 32'h8000_0300; timer_irq_i = 1'b1; sw_irq_i = 1'b1; ext_irq_i = 1'b1;
    push_exp(32'h8000_000B, 32'h8000_0300, 32'd0, 1'b1, 2);
    check_trap(0, 1'b0);
    @(negedge clk_i);

    // Software beats timer
    ex_pc_i = 32'h8000_0310; timer_irq_i = 1'b1; sw_irq_i = 1'b1;
    push_exp(32'h8000_0003, 32'h8000_0310, 32'd0, 1'b1, 2);
    check_trap(0, 1'b0);
    @(negedge clk_i);

    // Drain: three stall cycles after capture
    ex_pc_i = 32'h8000_0400; ext_irq_i = 1'b1;
    push_exp(32'h8000_000B, 32'h8000_0400, 32'd0, 1'b1, 5);
    check_trap(3, 1'b0);
    @(negedge clk_i);

    // Global interrupt disable masks the timer
    mstatus_mie_i = 1'b0; timer_irq_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("masked_busy", {31'd0, busy_o}, 32'd0);
    end
    timer_irq_i = 1'b0; mstatus_mie_i = 1'b1;

    // Events without a valid EX instruction are ignored
    ex_valid_i = 1'b0; exc_valid_i = 1'b1; sw_irq_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("no_ex_valid_busy", {31'd0, busy_o}, 32'd0);
    end
    exc_valid_i = 1'b0; sw_irq_i = 1'b0; ex_valid_i = 1'b1;
    @(negedge clk_i);

    // Reset pulse while in DRAIN aborts the trap
    ex_pc_i = 32'h8000_0500; exc_cause_i = 32'd5; exc_tval_i = 32'h1234_5678;
    exc_valid_i = 1'b1; stall_i = 1'b1;
    @(negedge clk_i);
    exc_valid_i = 1'b0;
    chk("drain_busy", {31'd0, busy_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_flush", {31'd0, flush_o}, 32'd0);
    chk("abort_cause", trap_cause_o, 32'd0);
    chk("abort_mepc", trap_mepc_o, 32'd0);
    chk("abort_tval", trap_tval_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; stall_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("abort_no_commit", {31'd0, trap_active_o}, 32'd0);
      chk("abort_no_redirect", {31'd0, redirect_o}, 32'd0);
    end

    // Mode 01 mtvec: vectored for interrupts only when the feature is built in
    mtvec_i = 32'h8000_1001; ex_pc_i = 32'h8000_0600; timer_irq_i = 1'b1;
    push_exp(32'h8000_0007, 32'h8000_0600, 32'd0, 1'b1, 2);
    check_trap(0, 1'b0);
    @(negedge clk_i);
    ex_pc_i = 32'h8000_0700; exc_cause_i = 32'd7; exc_tval_i = 32'h0000_0abc; exc_valid_i = 1'b1;
    push_exp(32'd7, 32'h8000_0700, 32'h0000_0abc, 1'b0, 2);
    check_trap(0, 1'b0);
    @(negedge clk_i);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
